// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, ROM entry layout {half_div, beats}, counter widths, SILENCE.
package melody_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_NOTE,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam int HALF_W     = 13;  // clk cycles per half-period, 0 = rest
  localparam int BEATS_W    = 3;   // note length in beats, 0 = end marker
  localparam int IDX_W      = 5;   // ROM index width (32 entries)
  localparam int BEAT_CNT_W = 28;  // holds beats * BEAT_CYCLES - 1

  localparam logic [15:0] SILENCE = 16'h0000;

  // ROM word layout: half_div in [15:3], beats in [2:0].
  typedef struct packed {
    logic [HALF_W-1:0]  half_div;
    logic [BEATS_W-1:0] beats;
  } note_t;

  function automatic note_t rom_entry(input logic [HALF_W-1:0]  half_div,
                                      input logic [BEATS_W-1:0] beats);
    return '{half_div: half_div, beats: beats};
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Note table ROM: one {half_div, beats} entry per index.
// Latency: 1 clk (registered read; addr at edge n gives dat after edge n).
// Backpressure: none; reads every cycle.
// Ports: clk, addr[4:0] in; dat (note_t, 16b) out.
module melody_rom
  import melody_pkg::*;
#(
  parameter bit TEST_TABLE = 1'b0  // 1 selects the short characterisation table
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] addr,
  output note_t            dat
);

  note_t entry;

  always_comb begin
    entry = rom_entry('0, '0);
    if (TEST_TABLE) begin
      unique case (addr)
        5'd0:    entry = rom_entry(13'd3, 3'd1);  // tone, 1 beat
        5'd1:    entry = rom_entry(13'd0, 3'd2);  // rest, 2 beats
        default: entry = rom_entry(13'd0, 3'd0);  // end marker
      endcase
    end else begin
      unique case (addr)
        5'd0:    entry = rom_entry(13'd4780, 3'd1);
        5'd1:    entry = rom_entry(13'd4259, 3'd1);
        5'd2:    entry = rom_entry(13'd3794, 3'd1);
        5'd3:    entry = rom_entry(13'd4780, 3'd1);
        5'd4:    entry = rom_entry(13'd0,    3'd1);
        5'd5:    entry = rom_entry(13'd3794, 3'd2);
        5'd6:    entry = rom_entry(13'd3189, 3'd2);
        5'd7:    entry = rom_entry(13'd2390, 3'd4);
        default: entry = rom_entry(13'd0,    3'd0);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    dat <= entry;
  end

endmodule

// File: rtl/melody_sequencer.sv
// Plays the note table as a square wave on audio_left/right, gated by play/pause/stop/loop_en.
// Latency: play at edge k -> LOAD after k, NOTE after k+1, first +AMPL sample after k+2.
// Backpressure: none; pause freezes all timing and forces silence.
// Ports: clk, rst, play, pause, stop, loop_en in; audio_left/right[15:0], note_idx[4:0], busy, done out.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned BEAT_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 1_000_000,
  parameter int unsigned NUM_NOTES   = 32,
  parameter logic [15:0] AMPL        = 16'h4000,
  parameter bit          TEST_TABLE  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                play,
  input  logic                pause,
  input  logic                stop,
  input  logic                loop_en,
  output logic signed [15:0]  audio_left,
  output logic signed [15:0]  audio_right,
  output logic [IDX_W-1:0]    note_idx,
  output logic                busy,
  output logic                done
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NOTES - 1);
  localparam logic [15:0]      NEG_AMPL = ~AMPL + 16'd1;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx_nxt;
  logic [BEAT_CNT_W-1:0] beat_cnt, beat_nxt, beat_lim, lim_nxt;
  logic [GAP_W-1:0]      gap_cnt, gap_nxt;
  logic [HALF_W-1:0]     phase_cnt, phase_nxt, half_div, half_nxt;
  logic                  neg_half, neg_nxt;
  logic [15:0]           audio_q, audio_nxt;
  note_t                 rom_dat;
  logic                  idle_like;

  // ROM is addressed with the next index so the entry is already valid during LOAD.
  melody_rom #(.TEST_TABLE(TEST_TABLE)) u_rom (
    .clk  (clk),
    .addr (idx_nxt),
    .dat  (rom_dat)
  );

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      note_idx  <= '0;
      beat_cnt  <= '0;
      beat_lim  <= '0;
      gap_cnt   <= '0;
      phase_cnt <= '0;
      half_div  <= '0;
      neg_half  <= 1'b0;
      audio_q   <= SILENCE;
    end else begin
      state     <= state_nxt;
      note_idx  <= idx_nxt;
      beat_cnt  <= beat_nxt;
      beat_lim  <= lim_nxt;
      gap_cnt   <= gap_nxt;
      phase_cnt <= phase_nxt;
      half_div  <= half_nxt;
      neg_half  <= neg_nxt;
      audio_q   <= audio_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = note_idx;
    beat_nxt  = beat_cnt;
    lim_nxt   = beat_lim;
    gap_nxt   = gap_cnt;
    phase_nxt = phase_cnt;
    half_nxt  = half_div;
    neg_nxt   = neg_half;
    audio_nxt = SILENCE;

    if (stop) begin
      state_nxt = ST_IDLE;
      idx_nxt   = '0;
    end else if (pause) begin
      // Everything holds; only a start from IDLE/DONE is still accepted.
      if (play && idle_like) begin
        state_nxt = ST_LOAD;
        idx_nxt   = '0;
      end
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (play) begin
            state_nxt = ST_LOAD;
            idx_nxt   = '0;
          end
        end
        ST_LOAD: begin
          if (rom_dat.beats == '0) begin
            if (loop_en) begin
              state_nxt = ST_LOAD;
              idx_nxt   = '0;
            end else begin
              state_nxt = ST_DONE;
            end
          end else begin
            state_nxt = ST_NOTE;
            beat_nxt  = '0;
            phase_nxt = '0;
            neg_nxt   = 1'b0;
            half_nxt  = rom_dat.half_div;
            // Terminal count computed once per note so NOTE only needs a compare.
            lim_nxt   = BEAT_CNT_W'(rom_dat.beats * BEAT_CYCLES - 1);
          end
        end
        ST_NOTE: begin
          if (half_div != '0) begin
            audio_nxt = neg_half ? NEG_AMPL : AMPL;
          end
          if ((half_div != '0) && (phase_cnt == half_div - 13'd1)) begin
            phase_nxt = '0;
            neg_nxt   = ~neg_half;
          end else begin
            phase_nxt = phase_cnt + 1'b1;
          end
          if (beat_cnt == beat_lim) begin
            state_nxt = ST_GAP;
            gap_nxt   = '0;
          end else begin
            beat_nxt = beat_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (note_idx == IDX_LAST) begin
              if (loop_en) begin
                state_nxt = ST_LOAD;
                idx_nxt   = '0;
              end else begin
                state_nxt = ST_DONE;
              end
            end else begin
              state_nxt = ST_LOAD;
              idx_nxt   = note_idx + 1'b1;
            end
          end else begin
            gap_nxt = gap_cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  assign audio_left  = audio_q;
  assign audio_right = audio_q;
  assign busy        = (state == ST_LOAD) || (state == ST_NOTE) || (state == ST_GAP);
  assign done        = (state == ST_DONE);

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer using the short test table.
// Reference: a precomputed per-cycle waveform for one pass of the table, consumed one entry per unpaused cycle.
// Ports: drives clk, rst, play, pause, stop, loop_en; observes audio, note_idx, busy, done.
module tb_melody_sequencer;

  localparam int          BEAT = 8;
  localparam int          GAP  = 2;
  localparam logic [15:0] AMP  = 16'h1000;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        play = 1'b0, pause = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [15:0] audio_left, audio_right;
  logic [4:0]  note_idx;
  logic        busy, done;

  int errors = 0;
  int checks = 0;

  // One full pass of the table: per active cycle, the sample it produces and the index shown.
  logic [15:0] tl_smp[$];
  int          tl_idx[$];

  int          m_mode = M_IDLE;
  int          m_pos  = 0;
  logic [15:0] e_audio = 16'h0;
  int          e_idx  = 0;

  melody_sequencer #(
    .BEAT_CYCLES (BEAT),
    .GAP_CYCLES  (GAP),
    .NUM_NOTES   (32),
    .AMPL        (AMP),
    .TEST_TABLE  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .play        (play),
    .pause       (pause),
    .stop        (stop),
    .loop_en     (loop_en),
    .audio_left  (audio_left),
    .audio_right (audio_right),
    .note_idx    (note_idx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic build_timeline();
    int half[3]  = '{3, 0, 0};
    int beats[3] = '{1, 2, 0};
    for (int i = 0; i < 3; i++) begin
      tl_idx.push_back(i); tl_smp.push_back(16'h0);          // fetch cycle
      if (beats[i] == 0) break;                               // end marker
      for (int j = 0; j < beats[i] * BEAT; j++) begin
        tl_idx.push_back(i);
        if (half[i] == 0) tl_smp.push_back(16'h0);
        else if (((j / half[i]) % 2) == 1) tl_smp.push_back(16'h0000 - AMP);
        else tl_smp.push_back(AMP);
      end
      for (int g = 0; g < GAP; g++) begin
        tl_idx.push_back(i); tl_smp.push_back(16'h0);
      end
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_mode = M_IDLE; e_audio = 16'h0; e_idx = 0;
      return;
    end
    e_audio = 16'h0;
    if (stop) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_RUN && !pause) begin
      e_audio = tl_smp[m_pos];
      if (m_pos == tl_smp.size() - 1) begin
        if (loop_en) m_pos = 0;
        else m_mode = M_DONE;
      end else begin
        m_pos++;
      end
    end else if (m_mode != M_RUN && play) begin
      m_mode = M_RUN; m_pos = 0;
    end
    if (m_mode == M_RUN) e_idx = tl_idx[m_pos];
    else if (m_mode == M_DONE) e_idx = tl_idx[tl_idx.size() - 1];
    else e_idx = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("audio_left",  audio_left,  e_audio);
    chk("audio_right", audio_right, e_audio);
    chk("note_idx",    note_idx,    e_idx);
    chk("busy",        busy,        m_mode == M_RUN);
    chk("done",        done,        m_mode == M_DONE);
  endtask

  initial begin
    build_timeline();

    // Reset state
    step(); step();
    rst = 1'b0;
    step(); step();

    // Tone, rest, end marker, loop_en=0
    play = 1'b1; step(); play = 1'b0;
    for (int n = 0; n < 36; n++) begin
      step();
      if (n == 1) chk("first_sample", audio_left, 16'h1000);
      if (n == 4) chk("first_flip", audio_left, 16'hF000);
    end
    chk("end_done", done, 1'b1);
    chk("end_busy", busy, 1'b0);

    // Looping from DONE
    loop_en = 1'b1;
    play = 1'b1; step(); play = 1'b0;
    for (int n = 0; n < 70; n++) begin
      step();
      if (n == 30) begin
        chk("loop_restart_idx", note_idx, 5'd0);
        chk("loop_still_busy", busy, 1'b1);
      end
    end
    loop_en = 1'b0;
    for (int n = 0; n < 40; n++) step();

    // Pause for 5 cycles mid-note
    stop = 1'b1; step(); stop = 1'b0;
    play = 1'b1; step(); play = 1'b0;
    for (int n = 0; n < 3; n++) step();
    pause = 1'b1;
    for (int n = 0; n < 5; n++) step();
    pause = 1'b0;
    for (int n = 0; n < 20; n++) step();

    // stop + play together mid-gap
    stop = 1'b1; step(); stop = 1'b0;
    play = 1'b1; step(); play = 1'b0;
    for (int n = 0; n < 9; n++) step();
    stop = 1'b1; play = 1'b1; step(); stop = 1'b0; play = 1'b0;
    chk("stopplay_busy", busy, 1'b0);
    chk("stopplay_idx", note_idx, 5'd0);
    chk("stopplay_audio", audio_left, 16'h0);

    // Asynchronous reset mid-note
    play = 1'b1; step(); play = 1'b0;
    for (int n = 0; n < 4; n++) step();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_audio", audio_left, 16'h0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_idx", note_idx, 5'd0);
    step(); step();
    rst = 1'b0;
    play = 1'b1; step(); play = 1'b0;
    for (int n = 0; n < 15; n++) step();

    // Random control traffic
    for (int n = 0; n < 800; n++) begin
      play = ($urandom_range(0, 9) == 0);
      stop = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      if ($urandom_range(0, 49) == 0) loop_en = ~loop_en;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
